// File: rtl/response_router.sv
`default_nettype none
// ============================================================================
// Module      : response_router
// Description : Routes memory response beats back to the requester port that
//               issued the matching transaction ID. Requests are recorded in
//               an external ID table through insert commands. Each response
//               beat is looked up in that table and forwarded to the owning
//               port. The last beat of a burst retires the table entry.
//               Beats that miss the table are dropped and raise a sticky
//               error.
// Ports       : clock/reset            - sole clock, async active-high reset
//               req_*                  - request recording handshake
//               rsp_*                  - memory response beat handshake
//               tbl_*                  - ID table command/answer interface
//               port_*                 - per-port response delivery
//               outstanding            - live table entry count
//               error                  - sticky miss/underflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module response_router #(
   parameter int NUMBER_OF_PORTS   = 2,
   parameter int ID_WIDTH          = 16,
   parameter int DATA_WIDTH        = 64,
   parameter int NUMBER_OF_ENTRIES = 32
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [ID_WIDTH-1:0]                   req_id,
   input  logic [$clog2(NUMBER_OF_PORTS)-1:0]    req_origin,
   input  logic                                  rsp_valid,
   output logic                                  rsp_ready,
   input  logic [ID_WIDTH-1:0]                   rsp_id,
   input  logic [DATA_WIDTH-1:0]                 rsp_data,
   input  logic                                  rsp_last,
   output logic [ID_WIDTH-1:0]                   tbl_id,
   output logic [$clog2(NUMBER_OF_PORTS)-1:0]    tbl_origin,
   output logic                                  tbl_insert,
   output logic                                  tbl_lookup,
   output logic                                  tbl_invalidate,
   input  logic                                  tbl_hit,
   input  logic [$clog2(NUMBER_OF_PORTS)-1:0]    tbl_answer_origin,
   output logic [NUMBER_OF_PORTS-1:0]            port_valid,
   input  logic [NUMBER_OF_PORTS-1:0]            port_ready,
   output logic [DATA_WIDTH-1:0]                 port_data,
   output logic                                  port_last,
   output logic [$clog2(NUMBER_OF_ENTRIES):0]    outstanding,
   output logic                                  error
);

   localparam int ORIGIN_W = $clog2(NUMBER_OF_PORTS);
   localparam int CNT_W    = $clog2(NUMBER_OF_ENTRIES) + 1;

   localparam logic [CNT_W-1:0] c_FULL = CNT_W'(NUMBER_OF_ENTRIES);
   localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOOKUP  = 3'd1;
   localparam logic [2:0] FORWARD = 3'd2;
   localparam logic [2:0] RETIRE  = 3'd3;
   localparam logic [2:0] DROP    = 3'd4;

   logic [2:0]            r_state;
   logic [2:0]            w_next_state;
   logic [ID_WIDTH-1:0]   r_id;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_last;
   logic [ORIGIN_W-1:0]   r_origin;
   logic [CNT_W-1:0]      r_outstanding;
   logic                  r_error;

   logic w_rsp_fire;
   logic w_req_fire;
   logic w_port_fire;

   // Combinational handshake outputs are gated by reset so that nothing is
   // advertised while reset is held, even though the FSM already sits in IDLE.
   assign rsp_ready  = (r_state == IDLE) && !reset;
   // Responses take priority: a pending beat blocks new requests.
   assign req_ready  = (r_state == IDLE) && !rsp_valid && !reset &&
                       (r_outstanding < c_FULL);
   assign w_rsp_fire = rsp_valid && rsp_ready;
   assign w_req_fire = req_valid && req_ready;

   assign port_valid  = (r_state == FORWARD) ? (NUMBER_OF_PORTS'(1) << r_origin) : '0;
   assign port_data   = r_data;
   assign port_last   = r_last;
   // Only the selected port's ready counts, since port_valid is one-hot.
   assign w_port_fire = |(port_valid & port_ready);

   // Table commands are mutually exclusive by construction: insert only
   // happens in IDLE, lookup only in LOOKUP, invalidate only in RETIRE.
   assign tbl_insert     = w_req_fire;
   assign tbl_lookup     = (r_state == LOOKUP);
   assign tbl_invalidate = (r_state == RETIRE);
   assign tbl_id         = tbl_insert ? req_id :
                           (tbl_lookup || tbl_invalidate) ? r_id : '0;
   assign tbl_origin     = tbl_insert ? req_origin : '0;

   assign outstanding = r_outstanding;
   assign error       = r_error;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_rsp_fire)  w_next_state = LOOKUP;
         LOOKUP:  w_next_state = tbl_hit ? FORWARD : DROP;
         FORWARD: if (w_port_fire) w_next_state = r_last ? RETIRE : IDLE;
         RETIRE:  w_next_state = IDLE;
         DROP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_id          <= '0;
         r_data        <= '0;
         r_last        <= 1'b0;
         r_origin      <= '0;
         r_outstanding <= '0;
         r_error       <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_rsp_fire) begin
            r_id   <= rsp_id;
            r_data <= rsp_data;
            r_last <= rsp_last;
         end
         if ((r_state == LOOKUP) && tbl_hit) begin
            r_origin <= tbl_answer_origin;
         end
         // Insert (IDLE) and retire (RETIRE) can never coincide.
         if (w_req_fire) begin
            r_outstanding <= r_outstanding + c_ONE;
         end else if (r_state == RETIRE) begin
            if (r_outstanding == '0) begin
               r_error <= 1'b1;
            end else begin
               r_outstanding <= r_outstanding - c_ONE;
            end
         end
         if (r_state == DROP) begin
            r_error <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_response_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_response_router
// Description : Directed self-checking bench for response_router with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_response_router;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_id;
   logic [0:0]  req_origin;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_id;
   logic [63:0] rsp_data;
   logic        rsp_last;
   logic [15:0] tbl_id;
   logic [0:0]  tbl_origin;
   logic        tbl_insert;
   logic        tbl_lookup;
   logic        tbl_invalidate;
   logic        tbl_hit;
   logic [0:0]  tbl_answer_origin;
   logic [1:0]  port_valid;
   logic [1:0]  port_ready;
   logic [63:0] port_data;
   logic        port_last;
   logic [5:0]  outstanding;
   logic        error;

   int n_cmp = 0;
   int n_err = 0;
   int n_lk  = 0;
   int n_inv = 0;

   response_router dut (
      .clock             (clock),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_id            (req_id),
      .req_origin        (req_origin),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_id            (rsp_id),
      .rsp_data          (rsp_data),
      .rsp_last          (rsp_last),
      .tbl_id            (tbl_id),
      .tbl_origin        (tbl_origin),
      .tbl_insert        (tbl_insert),
      .tbl_lookup        (tbl_lookup),
      .tbl_invalidate    (tbl_invalidate),
      .tbl_hit           (tbl_hit),
      .tbl_answer_origin (tbl_answer_origin),
      .port_valid        (port_valid),
      .port_ready        (port_ready),
      .port_data         (port_data),
      .port_last         (port_last),
      .outstanding       (outstanding),
      .error             (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts table commands seen at each active edge.
   always @(posedge clock) begin
      if (tbl_lookup)     n_lk  = n_lk + 1;
      if (tbl_invalidate) n_inv = n_inv + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; req_valid = 0; req_id = '0; req_origin = '0;
      rsp_valid = 0; rsp_id = '0; rsp_data = '0; rsp_last = 0;
      tbl_hit = 0; tbl_answer_origin = '0; port_ready = '0;

      // Reset state
      tick(); tick();
      check_eq("rst_rsp_ready", rsp_ready, 0);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_outstanding", outstanding, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_port_valid", port_valid, 0);
      reset = 1'b0;

      // Single request then single-beat response to port 1
      tick();
      req_valid = 1; req_id = 16'h12; req_origin = 1'b1;
      #1;
      check_eq("t1_req_ready", req_ready, 1);
      check_eq("t1_insert", tbl_insert, 1);
      check_eq("t1_ins_id", tbl_id, 16'h12);
      check_eq("t1_ins_origin", tbl_origin, 1);
      tick();
      req_valid = 0;
      #1;
      check_eq("t1_out_1", outstanding, 1);
      check_eq("t1_idle_id", tbl_id, 0);
      rsp_valid = 1; rsp_id = 16'h12; rsp_data = 64'hAA; rsp_last = 1;
      tbl_hit = 1; tbl_answer_origin = 1'b1;
      #1;
      check_eq("t1_rsp_ready", rsp_ready, 1);
      check_eq("t1_req_blocked", req_ready, 0);
      tick();
      rsp_valid = 0;
      #1;
      check_eq("t1_lookup", tbl_lookup, 1);
      check_eq("t1_lookup_id", tbl_id, 16'h12);
      check_eq("t1_lookup_origin", tbl_origin, 0);
      check_eq("t1_pv_early", port_valid, 0);
      tick();
      check_eq("t1_port_valid", port_valid, 2'b10);
      check_eq("t1_port_data", port_data, 64'hAA);
      check_eq("t1_port_last", port_last, 1);
      port_ready = 2'b10;
      tick();
      port_ready = 2'b00;
      #1;
      check_eq("t1_inval", tbl_invalidate, 1);
      check_eq("t1_inval_id", tbl_id, 16'h12);
      check_eq("t1_pv_off", port_valid, 0);
      tick();
      check_eq("t1_out_0", outstanding, 0);
      check_eq("t1_inval_off", tbl_invalidate, 0);
      check_eq("t1_error", error, 0);

      // Miss: beat is dropped
      rsp_valid = 1; rsp_id = 16'h55; rsp_data = 64'h1; rsp_last = 1; tbl_hit = 0;
      tick();
      rsp_valid = 0;
      #1;
      check_eq("t2_lookup", tbl_lookup, 1);
      check_eq("t2_err_pre", error, 0);
      tick();
      check_eq("t2_drop_pv", port_valid, 0);
      check_eq("t2_drop_cmd", {tbl_insert, tbl_lookup, tbl_invalidate}, 0);
      tick();
      check_eq("t2_error", error, 1);
      check_eq("t2_idle", rsp_ready, 1);
      check_eq("t2_out", outstanding, 0);

      // Simultaneous req and rsp: response wins
      req_valid = 1; req_id = 16'h20; req_origin = 1'b0;
      rsp_valid = 1; rsp_id = 16'h77; tbl_hit = 0;
      #1;
      check_eq("t3_req_ready", req_ready, 0);
      check_eq("t3_no_insert", tbl_insert, 0);
      check_eq("t3_rsp_ready", rsp_ready, 1);
      tick();
      rsp_valid = 0;
      #1;
      check_eq("t3_lk_req_ready", req_ready, 0);
      tick();
      check_eq("t3_drop_req_ready", req_ready, 0);
      tick();
      check_eq("t3_idle_req_ready", req_ready, 1);
      check_eq("t3_insert", tbl_insert, 1);
      check_eq("t3_insert_id", tbl_id, 16'h20);
      tick();
      check_eq("t3_out", outstanding, 1);

      // Fill the table to capacity
      for (int i = 0; i < 31; i++) begin
         req_id = 16'h100 + 16'(i);
         tick();
      end
      check_eq("t4_out_full", outstanding, 32);
      check_eq("t4_req_ready_full", req_ready, 0);
      check_eq("t4_no_insert", tbl_insert, 0);
      req_valid = 0;
      rsp_valid = 1; rsp_id = 16'h20; rsp_data = 64'h5A5A; rsp_last = 1;
      tbl_hit = 1; tbl_answer_origin = 1'b0;
      #1;
      check_eq("t4_rsp_ready_full", rsp_ready, 1);
      tick();
      rsp_valid = 0;
      tick();
      check_eq("t4_port_valid", port_valid, 2'b01);
      port_ready = 2'b01;
      tick();
      port_ready = 2'b00;
      tick();
      check_eq("t4_out_31", outstanding, 31);
      check_eq("t4_req_ready", req_ready, 1);

      // Four-beat burst to port 0 with a stall on beat 2
      n_lk = 0; n_inv = 0;
      tbl_hit = 1; tbl_answer_origin = 1'b0;
      for (int b = 0; b < 4; b++) begin
         rsp_valid = 1; rsp_id = 16'h101; rsp_data = 64'h1000 + 64'(b);
         rsp_last = (b == 3);
         tick();
         rsp_valid = 0;
         tick();
         check_eq("t5_port_valid", port_valid, 2'b01);
         check_eq("t5_port_data", port_data, 64'h1000 + 64'(b));
         check_eq("t5_port_last", port_last, (b == 3) ? 1 : 0);
         if (b == 1) begin
            for (int k = 0; k < 5; k++) begin
               tick();
               check_eq("t5_stall_valid", port_valid, 2'b01);
               check_eq("t5_stall_data", port_data, 64'h1001);
            end
         end
         port_ready = 2'b01;
         tick();
         port_ready = 2'b00;
         if (b == 3) tick();
      end
      check_eq("t5_lookups", n_lk, 4);
      check_eq("t5_invals", n_inv, 1);
      check_eq("t5_out", outstanding, 30);

      // Reset while forwarding
      rsp_valid = 1; rsp_id = 16'h102; rsp_data = 64'hBEEF; rsp_last = 0;
      tbl_hit = 1; tbl_answer_origin = 1'b1;
      tick();
      rsp_valid = 0;
      tick();
      check_eq("t6_port_valid", port_valid, 2'b10);
      reset = 1;
      #1;
      check_eq("t6_rst_pv", port_valid, 0);
      check_eq("t6_rst_out", outstanding, 0);
      check_eq("t6_rst_rsp_ready", rsp_ready, 0);
      check_eq("t6_rst_err", error, 0);
      check_eq("t6_rst_data", port_data, 0);
      check_eq("t6_rst_cmd", {tbl_insert, tbl_lookup, tbl_invalidate}, 0);
      tick(); tick();
      reset = 0;
      #1;
      check_eq("t6_rsp_ready", rsp_ready, 1);

      // Retire with nothing outstanding
      rsp_valid = 1; rsp_id = 16'h9; rsp_data = 64'h3; rsp_last = 1;
      tbl_hit = 1; tbl_answer_origin = 1'b1; port_ready = 2'b10;
      tick();
      rsp_valid = 0;
      tick();
      check_eq("t7_port_valid", port_valid, 2'b10);
      check_eq("t7_err_pre", error, 0);
      tick();
      check_eq("t7_inval", tbl_invalidate, 1);
      check_eq("t7_inval_id", tbl_id, 16'h9);
      port_ready = 2'b00;
      tick();
      check_eq("t7_out", outstanding, 0);
      check_eq("t7_error", error, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/response_router.md
RESPONSE_ROUTER -- requirements
Module: response_router

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_PORTS, default 2, meaning the number of requester ports.
REQ-002 The block SHALL have parameter ID_WIDTH, default 16, meaning the transaction ID width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 64, meaning the response data width.
REQ-004 The block SHALL have parameter NUMBER_OF_ENTRIES, default 32, meaning the ID table capacity.
REQ-005 The block SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-006 Ports (name  direction  width  meaning):
- clock  in  1  sole clock.
- reset  in  1  async active-high reset.
- req_valid  in  1  issued request to record.
- req_ready  out  1  request accepted.
- req_id  in  ID_WIDTH  request ID.
- req_origin  in  $clog2(NUMBER_OF_PORTS)  issuing port.
- rsp_valid  in  1  memory response beat.
- rsp_ready  out  1  beat accepted.
- rsp_id  in  ID_WIDTH  beat ID.
- rsp_data  in  DATA_WIDTH  beat data.
- rsp_last  in  1  final beat of burst.
- tbl_id  out  ID_WIDTH  ID presented to table.
- tbl_origin  out  $clog2(NUMBER_OF_PORTS)  origin presented to table.
- tbl_insert / tbl_lookup / tbl_invalidate  out  1 each  table commands.
- tbl_hit  in  1  combinational table match.
- tbl_answer_origin  in  $clog2(NUMBER_OF_PORTS)  origin of the matching entry.
- port_valid  out  NUMBER_OF_PORTS  per-port beat valid.
- port_ready  in  NUMBER_OF_PORTS  per-port ready.
- port_data  out  DATA_WIDTH  shared beat data.
- port_last  out  1  shared last flag.
- outstanding  out  $clog2(NUMBER_OF_ENTRIES)+1  live table entries.
- error  out  1  sticky miss/underflow flag.

Function
REQ-007 The FSM SHALL have states IDLE, LOOKUP, FORWARD, RETIRE, DROP.
REQ-008 In IDLE, rsp_ready=1; a rsp handshake SHALL capture id/data/last into holding registers and go to LOOKUP.
REQ-009 In IDLE with rsp_valid=0, req_ready SHALL equal (outstanding < NUMBER_OF_ENTRIES); req_ready=0 in all other states and whenever rsp_valid=1 (responses take priority).
REQ-010 On a req handshake: tbl_insert=1, tbl_id=req_id, tbl_origin=req_origin that cycle; outstanding increments at the next edge.
REQ-011 In LOOKUP: tbl_lookup=1, tbl_id=held ID; on tbl_hit=1, latch tbl_answer_origin and go to FORWARD; otherwise go to DROP.
REQ-012 In FORWARD: port_valid[latched origin]=1, all other bits 0; port_data/port_last from holding registers, stable until handshake.
REQ-013 On port_ready[origin]=1 in FORWARD: go to RETIRE if held last=1, else IDLE.
REQ-014 In RETIRE: tbl_invalidate=1, tbl_id=held ID for exactly one cycle; outstanding decrements; next state IDLE.
REQ-015 In DROP: beat discarded, error set, next state IDLE; no table command issued.
REQ-016 Each non-last beat SHALL re-do the lookup; only the last beat invalidates.
REQ-017 Minimum latency: rsp handshake cycle N -> port_valid at cycle N+2; minimum beat spacing 3 cycles (4 for last).
REQ-018 At most one of tbl_insert/tbl_lookup/tbl_invalidate SHALL be high in any cycle.
REQ-019 Table command outputs SHALL be 0 and tbl_id/tbl_origin SHALL be 0 when no command is active.
REQ-020 If RETIRE occurs with outstanding=0, outstanding SHALL stay 0 and error SHALL be set.
REQ-021 When outstanding=NUMBER_OF_ENTRIES, req_ready=0; responses are still accepted.

Reset
REQ-022 Reset SHALL asynchronously force state IDLE, outstanding=0, error=0, holding registers=0.
REQ-023 During reset, all outputs SHALL be 0 except rsp_ready, which is 0 while reset is high.
REQ-024 Reset mid-FORWARD SHALL drop port_valid immediately and lose the held beat without a table command.
REQ-025 error SHALL clear only on reset.

Verification
REQ-026 Req id=0x12, origin=1, then rsp id=0x12 last=1 data=0xAA -> insert in the handshake cycle; port_valid=2'b10 two cycles after rsp handshake; invalidate for id 0x12 one cycle after port handshake; outstanding 1->0.
REQ-027 Rsp id=0x55 with tbl_hit=0 -> no port_valid, error=1, back to IDLE after 3 cycles, outstanding unchanged.
REQ-028 Fill 32 requests -> req_ready=0 at outstanding=32; one completed last beat -> req_ready=1 next IDLE cycle.
REQ-029 4-beat burst to port 0 with port_ready held 0 for 5 cycles on beat 2 -> data stable, one lookup per beat, single invalidate after beat 4.
REQ-030 rsp_valid and req_valid both high in IDLE -> rsp accepted, req_ready=0 until FSM returns to IDLE with rsp_valid=0.
REQ-031 Reset asserted while in FORWARD -> port_valid=0 and outstanding=0 without waiting for a clock edge.
